// File: rtl/alu_entry_sequencer_if.sv
// Button and register-bank control bundle for the ALU entry sequencer.
// The board side drives the raw buttons; the sequencer drives the load
// strobes and the stage indicators.
interface alu_entry_sequencer_if;
  logic       BTNC;
  logic       BTNL;
  logic       load_op1;
  logic       load_op2;
  logic       load_opcode;
  logic       result_valid;
  logic [1:0] stage;
  logic [3:0] stage_led;

  modport master (
    output BTNC, BTNL,
    input  load_op1, load_op2, load_opcode, result_valid, stage, stage_led
  );

  modport slave (
    input  BTNC, BTNL,
    output load_op1, load_op2, load_opcode, result_valid, stage, stage_led
  );
endinterface

// File: rtl/alu_entry_sequencer.sv
// Guided operand/opcode entry controller: turns the Enter (BTNC) and Back
// (BTNL) buttons into a walk through OP1 -> OP2 -> OPCODE -> RESULT,
// firing a one-cycle load strobe into the register bank on each forward
// step out of an entry stage.
// DEBOUNCE_CYCLES and SYNC_STAGES must both be at least 2.
module alu_entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input logic                   CLK100MHZ,
  input logic                   CPU_RESETN,
  alu_entry_sequencer_if.slave  btn_bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OP1    = 2'd0,
    ST_OP2    = 2'd1,
    ST_OPCODE = 2'd2,
    ST_RESULT = 2'd3
  } stage_t;

  // Index 0 is the Enter button, index 1 is the Back button.
  logic [1:0]             raw_btn;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [CNT_W-1:0]       cnt_q  [2];
  logic [1:0]             stable_q;
  logic [1:0]             stable_d_q;
  logic [1:0]             press_q;
  logic                   enter_p;
  logic                   back_p;

  stage_t                 stage_q;
  stage_t                 stage_n;
  logic [2:0]             load_q;
  logic [2:0]             load_n;

  assign raw_btn = {btn_bus.BTNL, btn_bus.BTNC};
  assign enter_p = press_q[0];
  assign back_p  = press_q[1];

  // Bring both raw buttons into the clock domain through a flop chain.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < 2; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_btn[i]};
    end
  end

  // Flip the stable level only after the synchronized level has disagreed
  // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      stable_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i][SYNC_STAGES-1] != stable_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            stable_q[i] <= ~stable_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // One-cycle press pulse on each rising edge of the debounced level.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      stable_d_q <= '0;
      press_q    <= '0;
    end else begin
      stable_d_q <= stable_q;
      press_q    <= stable_q & ~stable_d_q;
    end
  end

  // Stage register; strobes are registered alongside so they carry no
  // combinational path back to the buttons.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      stage_q <= ST_OP1;
      load_q  <= '0;
    end else begin
      stage_q <= stage_n;
      load_q  <= load_n;
    end
  end

  // Next stage and strobe selection; Enter wins when both pulses coincide.
  always_comb begin
    stage_n = stage_q;
    load_n  = '0;
    if (enter_p) begin
      case (stage_q)
        ST_OP1:    begin stage_n = ST_OP2;    load_n = 3'b001; end
        ST_OP2:    begin stage_n = ST_OPCODE; load_n = 3'b010; end
        ST_OPCODE: begin stage_n = ST_RESULT; load_n = 3'b100; end
        default:   begin stage_n = ST_OP1; end
      endcase
    end else if (back_p) begin
      case (stage_q)
        ST_OP2:    stage_n = ST_OP1;
        ST_OPCODE: stage_n = ST_OP2;
        ST_RESULT: stage_n = ST_OPCODE;
        default:   stage_n = ST_OP1;
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    btn_bus.load_op1     = load_q[0];
    btn_bus.load_op2     = load_q[1];
    btn_bus.load_opcode  = load_q[2];
    btn_bus.stage        = stage_q;
    btn_bus.result_valid = (stage_q == ST_RESULT);
    btn_bus.stage_led    = 4'b0001 << stage_q;
  end

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Randomized self-checking bench for alu_entry_sequencer, with a small
// stage-walk reference model and a strobe monitor.
module tb_alu_entry_sequencer;

  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_entry_sequencer_if bus ();

  alu_entry_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .btn_bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_op1    = 0;
  int n_op2    = 0;
  int n_opc    = 0;
  int m_stage  = 0;
  logic [2:0] strobes;
  logic [2:0] prev_strobes = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Count strobes and watch their exclusivity and width every cycle.
  always @(negedge clk) begin
    strobes = {bus.load_opcode, bus.load_op2, bus.load_op1};
    if (rst_n) begin
      if (strobes != 3'b000) begin
        checkOutput("strobe_onehot", $countones(strobes), 1);
        checkOutput("strobe_width", {29'd0, prev_strobes & strobes}, 0);
      end
      n_op1 += int'(strobes[0]);
      n_op2 += int'(strobes[1]);
      n_opc += int'(strobes[2]);
    end
    prev_strobes = strobes;
  end

  // Hard bound on total run time.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic driveButtons(input logic e, input logic b, input int cycles, input int idle);
    @(posedge clk); #1;
    bus.BTNC = e;
    bus.BTNL = b;
    repeat (cycles) @(posedge clk);
    #1;
    bus.BTNC = 1'b0;
    bus.BTNL = 1'b0;
    repeat (idle) @(posedge clk);
    #1;
  endtask

  task automatic checkStage();
    checkOutput("stage", {30'd0, bus.stage}, m_stage);
    checkOutput("stage_led", {28'd0, bus.stage_led}, 32'd1 << m_stage);
    checkOutput("result_valid", {31'd0, bus.result_valid}, (m_stage == 3) ? 1 : 0);
  endtask

  // kind: 0 Enter press, 1 Back press, 2 Enter glitch, 3 Back glitch, 4 both pressed together.
  task automatic applyStimulus(input int kind);
    int b1, b2, b3;
    int e1, e2, e3;
    b1 = n_op1; b2 = n_op2; b3 = n_opc;
    e1 = 0; e2 = 0; e3 = 0;
    case (kind)
      0, 4: begin
        driveButtons(1'b1, kind == 4, $urandom_range(6, 12), 14);
        if (m_stage == 0) e1 = 1;
        if (m_stage == 1) e2 = 1;
        if (m_stage == 2) e3 = 1;
        m_stage = (m_stage + 1) % 4;
      end
      1: begin
        driveButtons(1'b0, 1'b1, $urandom_range(6, 12), 14);
        if (m_stage > 0) m_stage = m_stage - 1;
      end
      2: driveButtons(1'b1, 1'b0, $urandom_range(1, DEB - 1), 10);
      default: driveButtons(1'b0, 1'b1, $urandom_range(1, DEB - 1), 10);
    endcase
    checkStage();
    checkOutput("op1_count", n_op1 - b1, e1);
    checkOutput("op2_count", n_op2 - b2, e2);
    checkOutput("opcode_count", n_opc - b3, e3);
  endtask

  initial begin
    int lat;
    int b1, b2, b3;
    bus.BTNC = 1'b0;
    bus.BTNL = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkStage();
    checkOutput("reset_strobes", {29'd0, bus.load_opcode, bus.load_op2, bus.load_op1}, 0);

    // Single held Enter press: latency is the press-pulse delay plus one FSM cycle.
    b1 = n_op1; b2 = n_op2; b3 = n_opc;
    lat = -1;
    @(posedge clk); #1;
    bus.BTNC = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (bus.load_op1 && lat < 0) lat = n;
    end
    bus.BTNC = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checkOutput("op1_latency", lat, SYNC + DEB + 2);
    m_stage = 1;
    checkStage();
    checkOutput("held_op1_count", n_op1 - b1, 1);
    checkOutput("held_other_count", (n_op2 - b2) + (n_opc - b3), 0);

    // Randomized walk through all stimulus kinds.
    for (int t = 0; t < 40; t++) applyStimulus($urandom_range(0, 4));

    // Simultaneous presses in OP2, then Back in OP1 and glitches in place.
    while (m_stage != 1) applyStimulus(0);
    applyStimulus(4);
    while (m_stage != 0) applyStimulus(0);
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);

    // Asynchronous reset while in RESULT with Enter held.
    while (m_stage != 3) applyStimulus(0);
    @(posedge clk); #1;
    bus.BTNC = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    m_stage = 0;
    checkStage();
    checkOutput("reset_strobes_async", {29'd0, bus.load_opcode, bus.load_op2, bus.load_op1}, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    b1 = n_op1; b2 = n_op2; b3 = n_opc;
    repeat (20) @(posedge clk);
    #1;
    m_stage = 1;
    checkStage();
    checkOutput("post_reset_op1_count", n_op1 - b1, 1);
    checkOutput("post_reset_other_count", (n_op2 - b2) + (n_opc - b3), 0);
    bus.BTNC = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checkStage();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
